// File: rtl/vga_fb_arbiter.sv
// Shares one single-port RGB333 framebuffer RAM between the x4-scaled VGA fetch
// and a host write port. The fetch owns every fourth active pixel; the host gets the rest.
module vga_fb_arbiter #(
  parameter int ACTIVE_WIDTH  = 640,
  parameter int ACTIVE_HEIGHT = 480,
  parameter int FB_WIDTH      = 160,
  parameter int FB_DEPTH      = 19200,
  parameter int VBLANK_ONLY   = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [11:0] i_HPos,
  input  logic [11:0] i_VPos,
  input  logic        i_Wr_Req,
  input  logic [14:0] i_Wr_Addr,
  input  logic [8:0]  i_Wr_Data,
  output logic        o_Wr_Ack,
  output logic        o_Wr_Err,
  output logic [14:0] o_Ram_Addr,
  output logic        o_Ram_Re,
  output logic        o_Ram_We,
  output logic [8:0]  o_Ram_Wdata,
  input  logic [8:0]  i_Ram_Data,
  output logic [8:0]  o_Pixel
);

  logic        active;
  logic        slot;
  logic        vblank_ok;
  logic        grant;
  logic        in_range;
  logic [14:0] row;
  logic [14:0] col;
  logic [14:0] row_base;
  logic [14:0] fetch_addr;
  logic [2:0]  act_pipe;
  logic        re_d;
  logic [8:0]  cap;

  assign active    = (i_HPos < 12'(ACTIVE_WIDTH)) && (i_VPos < 12'(ACTIVE_HEIGHT));
  assign slot      = active && (i_HPos[1:0] == 2'b00);
  assign vblank_ok = (VBLANK_ONLY == 0) || (i_VPos >= 12'(ACTIVE_HEIGHT));
  assign grant     = i_Wr_Req && !slot && !o_Wr_Ack && vblank_ok;
  assign in_range  = i_Wr_Addr < 15'(FB_DEPTH);

  assign row = 15'(i_VPos[11:2]);
  assign col = 15'(i_HPos[11:2]);

  // 160 = 128 + 32, so the default row stride needs no multiplier
  generate
    if (FB_WIDTH == 160) begin : g_shift_add
      assign row_base = (row << 7) + (row << 5);
    end else begin : g_mul
      assign row_base = 15'(row * FB_WIDTH);
    end
  endgenerate

  assign fetch_addr = row_base + col;

  // o_Pixel itself is the fourth stage of the active-flag delay
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      act_pipe    <= '0;
      re_d        <= 1'b0;
      cap         <= '0;
      o_Pixel     <= '0;
      o_Ram_Re    <= 1'b0;
      o_Ram_We    <= 1'b0;
      o_Ram_Addr  <= '0;
      o_Ram_Wdata <= '0;
      o_Wr_Ack    <= 1'b0;
      o_Wr_Err    <= 1'b0;
    end else begin
      act_pipe <= {act_pipe[1:0], active};
      re_d     <= o_Ram_Re;
      if (re_d) begin
        cap <= i_Ram_Data;
      end
      o_Pixel <= act_pipe[2] ? cap : 9'd0;

      if (slot) begin
        o_Ram_Re   <= 1'b1;
        o_Ram_We   <= 1'b0;
        o_Ram_Addr <= fetch_addr;
        o_Wr_Ack   <= 1'b0;
        o_Wr_Err   <= 1'b0;
      end else if (grant) begin
        o_Ram_Re <= 1'b0;
        o_Wr_Ack <= 1'b1;
        o_Ram_We <= in_range;
        o_Wr_Err <= !in_range;
        if (in_range) begin
          o_Ram_Addr  <= i_Wr_Addr;
          o_Ram_Wdata <= i_Wr_Data;
        end
      end else begin
        o_Ram_Re <= 1'b0;
        o_Ram_We <= 1'b0;
        o_Wr_Ack <= 1'b0;
        o_Wr_Err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a behavioural RAM plus a framebuffer
// reference model computed from position arithmetic.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] hpos = '0;
  logic [11:0] vpos = '0;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [8:0]  wr_data = '0;
  logic        wr_ack, wr_err, ram_re, ram_we;
  logic [14:0] ram_addr;
  logic [8:0]  ram_wdata, pixel;
  logic [8:0]  ram_data;

  logic [11:0] vb_hpos = '0;
  logic [11:0] vb_vpos = '0;
  logic        vb_req = 1'b0;
  logic [14:0] vb_addr = '0;
  logic [8:0]  vb_data = '0;
  logic [8:0]  vb_ram_data = '0;
  logic        vb_ack, vb_err, vb_re, vb_we;
  logic [14:0] vb_ram_addr;
  logic [8:0]  vb_wdata, vb_pixel;

  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [8:0]  pre_data = '0;
  logic [8:0]  mem     [0:19199];
  logic [8:0]  ref_mem [0:19199];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HPos(hpos), .i_VPos(vpos),
    .i_Wr_Req(wr_req), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
    .o_Wr_Ack(wr_ack), .o_Wr_Err(wr_err), .o_Ram_Addr(ram_addr),
    .o_Ram_Re(ram_re), .o_Ram_We(ram_we), .o_Ram_Wdata(ram_wdata),
    .i_Ram_Data(ram_data), .o_Pixel(pixel)
  );

  vga_fb_arbiter #(.VBLANK_ONLY(1)) dut_vb (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HPos(vb_hpos), .i_VPos(vb_vpos),
    .i_Wr_Req(vb_req), .i_Wr_Addr(vb_addr), .i_Wr_Data(vb_data),
    .o_Wr_Ack(vb_ack), .o_Wr_Err(vb_err), .o_Ram_Addr(vb_ram_addr),
    .o_Ram_Re(vb_re), .o_Ram_We(vb_we), .o_Ram_Wdata(vb_wdata),
    .i_Ram_Data(vb_ram_data), .o_Pixel(vb_pixel)
  );

  // Single-port RAM with one cycle of read latency; preload port has priority
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we && ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_data <= (ram_addr < 15'd19200) ? mem[ram_addr] : 9'd0;
  end

  function automatic logic [8:0] exp_pixel(input int h, input int v);
    if (h < 640 && v < 480) return ref_mem[(v / 4) * 160 + h / 4];
    return 9'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [8:0] d);
    pre_we = 1'b1; pre_addr = 15'(a); pre_data = d;
    hpos = 12'd1000; vpos = 12'd1000; wr_req = 1'b0;
    step();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic scan_check(input int v, input int h0, input int n, input string tag);
    logic [8:0] q[$];
    logic [8:0] e;
    int h;
    for (int c = 0; c < n + 4; c++) begin
      h = (c < n) ? h0 + c : 700;
      hpos = 12'(h); vpos = 12'(v);
      q.push_back(exp_pixel(h, v));
      step();
      n_checks++;
      if (h < 640 && v < 480 && h % 4 == 0) begin
        if (ram_re !== 1'b1 || ram_addr !== 15'((v / 4) * 160 + h / 4)) begin
          n_fail++;
          $display("FAIL %s fetch h=%0d v=%0d: re=%0b addr=%0d, expected re=1 addr=%0d",
                   tag, h, v, ram_re, ram_addr, (v / 4) * 160 + h / 4);
        end
      end else if (ram_re !== 1'b0) begin
        n_fail++;
        $display("FAIL %s no_fetch h=%0d v=%0d: re=%0b, expected 0", tag, h, v, ram_re);
      end
      if (c >= 3) begin
        e = q.pop_front();
        n_checks++;
        if (pixel !== e) begin
          n_fail++;
          $display("FAIL %s pixel cycle %0d: got %03h expected %03h", tag, c + 1, pixel, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hpos = '0; vpos = '0; wr_req = 1'b1; wr_addr = 15'd3; wr_data = 9'h1AB;
    vb_hpos = '0; vb_vpos = 12'd500; vb_req = 1'b1; vb_addr = 15'd3; vb_data = 9'h1AB;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({wr_ack, wr_err, ram_re, ram_we, ram_addr, ram_wdata, pixel} !== 38'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: ack=%0b err=%0b re=%0b we=%0b addr=%0d wdata=%03h pix=%03h, expected all 0",
                 wr_ack, wr_err, ram_re, ram_we, ram_addr, ram_wdata, pixel);
      end
      n_checks++;
      if ({vb_ack, vb_err, vb_re, vb_we, vb_ram_addr, vb_wdata, vb_pixel} !== 38'd0) begin
        n_fail++;
        $display("FAIL reset_outputs_vb: ack=%0b err=%0b re=%0b we=%0b addr=%0d, expected all 0",
                 vb_ack, vb_err, vb_re, vb_we, vb_ram_addr);
      end
    end
    wr_req = 1'b0; vb_req = 1'b0;
    hpos = 12'd1000; vpos = 12'd1000; vb_vpos = 12'd1000;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_fetch();
    preload(0, 9'h1FF);
    preload(1, 9'h049);
    preload(2, 9'h0C3);
    scan_check(0, 0, 8, "basic");
  endtask

  task automatic test_last_word();
    preload(19199, 9'h16B);
    scan_check(479, 636, 8, "last");
  endtask

  task automatic test_display_random();
    int r, v, h0;
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 119);
      for (int i = 0; i < 160; i++) preload(r * 160 + i, 9'($urandom));
      v = r * 4 + $urandom_range(0, 3);
      h0 = 4 * $urandom_range(0, 150);
      scan_check(v, h0, 40, "rand_disp");
    end
  endtask

  task automatic test_host_directed();
    vpos = 12'd0; wr_req = 1'b0;
    for (int h = 0; h < 3; h++) begin hpos = 12'(h); step(); end
    hpos = 12'd3; wr_req = 1'b1; wr_addr = 15'd5; wr_data = 9'h0AA;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd5 || ram_wdata !== 9'h0AA || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_h3: ack=%0b we=%0b addr=%0d wdata=%03h err=%0b, expected 1 1 5 0aa 0",
               wr_ack, ram_we, ram_addr, ram_wdata, wr_err);
    end
    ref_mem[5] = 9'h0AA;
    wr_req = 1'b0;
    for (int h = 4; h < 8; h++) begin hpos = 12'(h); step(); end
    hpos = 12'd8; wr_req = 1'b1; wr_addr = 15'd6; wr_data = 9'h133;
    step();
    n_checks++;
    if (wr_ack !== 1'b0 || ram_re !== 1'b1) begin
      n_fail++;
      $display("FAIL slot_priority: ack=%0b re=%0b, expected ack=0 re=1", wr_ack, ram_re);
    end
    hpos = 12'd9;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd6 || ram_wdata !== 9'h133) begin
      n_fail++;
      $display("FAIL grant_after_slot: ack=%0b we=%0b addr=%0d wdata=%03h, expected 1 1 6 133",
               wr_ack, ram_we, ram_addr, ram_wdata);
    end
    ref_mem[6] = 9'h133;
    wr_req = 1'b0; hpos = 12'd10;
    step();
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL no_dup_ack: ack=%0b, expected 0", wr_ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] d [3];
    int idx, last;
    for (int i = 0; i < 3; i++) d[i] = 9'($urandom);
    vpos = 12'd500; idx = 0; last = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      wr_req = (idx < 3);
      wr_addr = 15'(10 + idx);
      wr_data = (idx < 3) ? d[idx] : 9'd0;
      hpos = 12'(cyc);
      step();
      if (wr_ack === 1'b1) begin
        n_checks++;
        if (idx >= 3 || ram_we !== 1'b1 || ram_addr !== 15'(10 + idx) || ram_wdata !== d[idx]) begin
          n_fail++;
          $display("FAIL b2b_write %0d: we=%0b addr=%0d wdata=%03h, expected addr %0d", idx, ram_we, ram_addr, ram_wdata, 10 + idx);
        end
        if (idx > 0) begin
          n_checks++;
          if (cyc - last != 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: gap %0d cycles, expected 2", cyc - last);
          end
        end
        if (idx < 3) ref_mem[10 + idx] = d[idx];
        last = cyc;
        idx++;
      end
    end
    wr_req = 1'b0;
    n_checks++;
    if (idx != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d acks, expected 3", idx);
    end
    step();
    for (int i = 10; i < 13; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL b2b_ram[%0d]: got %03h expected %03h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_wr_error();
    vpos = 12'd500; hpos = 12'd3;
    for (int k = 0; k < 2; k++) begin
      wr_req = 1'b1;
      wr_addr = (k == 0) ? 15'd19200 : 15'($urandom_range(19201, 32767));
      wr_data = 9'h1C3;
      step();
      n_checks++;
      if (wr_ack !== 1'b1 || wr_err !== 1'b1 || ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_err addr=%0d: ack=%0b err=%0b we=%0b, expected 1 1 0", wr_addr, wr_ack, wr_err, ram_we);
      end
      wr_req = 1'b0;
      step();
      n_checks++;
      if (wr_ack !== 1'b0 || wr_err !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_err_clear: ack=%0b err=%0b, expected 0 0", wr_ack, wr_err);
      end
    end
  endtask

  task automatic test_host_random();
    int v, waited;
    logic pend, in_rng;
    logic [14:0] cur_addr;
    logic [8:0] cur_data;
    int written[$];
    v = $urandom_range(0, 479);
    pend = 1'b0; waited = 0; cur_addr = '0; cur_data = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1; waited = 0;
        cur_addr = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(19200, 32767))
                                                : 15'($urandom_range(0, 19199));
        cur_data = 9'($urandom);
      end
      wr_req = pend; wr_addr = cur_addr; wr_data = cur_data;
      hpos = 12'(cyc); vpos = 12'(v);
      step();
      if (cyc % 4 == 0) begin
        n_checks++;
        if (ram_re !== 1'b1 || wr_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_slot h=%0d: re=%0b ack=%0b, expected re=1 ack=0", cyc, ram_re, wr_ack);
        end
      end
      if (pend) begin
        if (wr_ack === 1'b1) begin
          in_rng = cur_addr < 15'd19200;
          n_checks++;
          if (ram_we !== in_rng || wr_err !== !in_rng || (in_rng && (ram_addr !== cur_addr || ram_wdata !== cur_data))) begin
            n_fail++;
            $display("FAIL rand_write addr=%0d: we=%0b err=%0b ram_addr=%0d wdata=%03h, expected data %03h",
                     cur_addr, ram_we, wr_err, ram_addr, ram_wdata, cur_data);
          end
          if (in_rng) begin
            ref_mem[cur_addr] = cur_data;
            written.push_back(int'(cur_addr));
          end
          pend = 1'b0;
        end else begin
          waited++;
          n_checks++;
          if (waited > 2) begin
            n_fail++;
            $display("FAIL rand_starve: waited %0d cycles, expected at most 2", waited);
          end
        end
      end else begin
        n_checks++;
        if (wr_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_spurious_ack h=%0d: ack=%0b, expected 0", cyc, wr_ack);
        end
      end
    end
    wr_req = 1'b0; hpos = 12'd1000; vpos = 12'd1000;
    step();
    foreach (written[i]) begin
      n_checks++;
      if (mem[written[i]] !== ref_mem[written[i]]) begin
        n_fail++;
        $display("FAIL rand_ram[%0d]: got %03h expected %03h", written[i], mem[written[i]], ref_mem[written[i]]);
      end
    end
  endtask

  task automatic test_vblank_only();
    vb_req = 1'b1; vb_addr = 15'd7; vb_data = 9'h0F0; vb_vpos = 12'd100;
    for (int h = 0; h < 12; h++) begin
      vb_hpos = 12'(h);
      step();
      n_checks++;
      if (vb_ack !== 1'b0 || vb_we !== 1'b0) begin
        n_fail++;
        $display("FAIL vblank_hold h=%0d: ack=%0b we=%0b, expected 0 0", h, vb_ack, vb_we);
      end
    end
    vb_vpos = 12'd480; vb_hpos = 12'd0;
    step();
    n_checks++;
    if (vb_ack !== 1'b1 || vb_we !== 1'b1 || vb_ram_addr !== 15'd7 || vb_wdata !== 9'h0F0) begin
      n_fail++;
      $display("FAIL vblank_grant: ack=%0b we=%0b addr=%0d wdata=%03h, expected 1 1 7 0f0",
               vb_ack, vb_we, vb_ram_addr, vb_wdata);
    end
    vb_req = 1'b0;
    step();
  endtask

  task automatic test_reset_midline();
    preload(0, 9'h1FF);
    vpos = 12'd0;
    for (int h = 0; h < 6; h++) begin hpos = 12'(h); step(); end
    n_checks++;
    if (pixel !== exp_pixel(2, 0)) begin
      n_fail++;
      $display("FAIL pre_reset_pixel: got %03h expected %03h", pixel, exp_pixel(2, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_ack, wr_err, ram_re, ram_we, ram_addr, ram_wdata, pixel} !== 38'd0) begin
      n_fail++;
      $display("FAIL async_reset: ack=%0b err=%0b re=%0b we=%0b addr=%0d wdata=%03h pix=%03h, expected all 0",
               wr_ack, wr_err, ram_re, ram_we, ram_addr, ram_wdata, pixel);
    end
    wr_req = 1'b1; wr_addr = 15'd20; wr_data = 9'h111; hpos = 12'd6;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd20 || ram_wdata !== 9'h111 || pixel !== 9'd0) begin
      n_fail++;
      $display("FAIL rearbitrate: ack=%0b we=%0b addr=%0d wdata=%03h pix=%03h, expected 1 1 20 111 000",
               wr_ack, ram_we, ram_addr, ram_wdata, pixel);
    end
    ref_mem[20] = 9'h111;
    wr_req = 1'b0; hpos = 12'd7;
    step();
    n_checks++;
    if (wr_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rearbitrate_dup: ack=%0b, expected 0", wr_ack);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_last_word();
    test_display_random();
    test_host_directed();
    test_back_to_back();
    test_wr_error();
    test_host_random();
    test_vblank_only();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
